// File: rtl/seven_seg_scroller.sv
// Display stage for the signed 5-digit BCD product: latches the value and scans a
// scrollable 4-symbol window of "sign + 5 digits" onto a multiplexed 7-segment display.
module seven_seg_scroller #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] bcd,
    input  logic        sign,
    input  logic        valid,
    input  logic        scroll_left,
    input  logic        scroll_right,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [1:0] OFFSET_MAX = 2'd2;

    logic [19:0]      data_q, data_d;
    logic             sign_q, sign_d;
    logic [1:0]       offset_q, offset_d;
    logic [CNT_W-1:0] refreshCnt_q, refreshCnt_d;
    logic [1:0]       pos_q, pos_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic [2:0]       symIdx;
    logic [3:0]       symNib;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q       <= '0;
            sign_q       <= 1'b0;
            offset_q     <= '0;
            refreshCnt_q <= '0;
            pos_q        <= '0;
            an_q         <= 4'b1111;
            seg_q        <= SEG_BLANK;
        end else begin
            data_q       <= data_d;
            sign_q       <= sign_d;
            offset_q     <= offset_d;
            refreshCnt_q <= refreshCnt_d;
            pos_q        <= pos_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    always_comb begin
        data_d = data_q;
        sign_d = sign_q;
        if (valid) begin
            data_d = bcd;
            sign_d = sign;
        end

        offset_d = offset_q;
        case ({scroll_left, scroll_right})
            2'b10: if (offset_q != OFFSET_MAX) offset_d = offset_q + 2'd1;
            2'b01: if (offset_q != 2'd0)       offset_d = offset_q - 2'd1;
            default: offset_d = offset_q;
        endcase

        refreshCnt_d = refreshCnt_q + CNT_W'(1);
        pos_d        = pos_q;
        if (refreshCnt_q == CNT_LAST) begin
            refreshCnt_d = '0;
            pos_d        = pos_q + 2'd1;
        end
    end

    // Output registers use the pre-edge pos/offset/data so anode and segments move together.
    always_comb begin
        symIdx = {1'b0, offset_q} + {1'b0, pos_q};
        symNib = 4'hF;
        case (symIdx)
            3'd0:    symNib = data_q[3:0];
            3'd1:    symNib = data_q[7:4];
            3'd2:    symNib = data_q[11:8];
            3'd3:    symNib = data_q[15:12];
            3'd4:    symNib = data_q[19:16];
            default: symNib = 4'hF;
        endcase

        if (symIdx == 3'd5)
            seg_d = sign_q ? SEG_MINUS : SEG_BLANK;
        else
            seg_d = glyph(symNib);

        an_d = ~(4'b0001 << pos_q);
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seven_seg_scroller.sv
// Directed bench for seven_seg_scroller with REFRESH_DIV=4; expectations are indexed by
// the number of clock edges since the last reset release.
module tb_seven_seg_scroller;

    localparam logic [6:0] G0     = 7'b1000000;
    localparam logic [6:0] G1     = 7'b1111001;
    localparam logic [6:0] G2     = 7'b0100100;
    localparam logic [6:0] G3     = 7'b0110000;
    localparam logic [6:0] G4     = 7'b0011001;
    localparam logic [6:0] G5     = 7'b0010010;
    localparam logic [6:0] GMINUS = 7'b0111111;
    localparam logic [6:0] GBLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] bcd;
    logic        sign;
    logic        valid;
    logic        scroll_left;
    logic        scroll_right;
    logic [3:0]  an;
    logic [6:0]  seg;

    int vectorCount = 0;
    int missCount   = 0;
    int e           = 0;

    seven_seg_scroller #(.REFRESH_DIV(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bcd          (bcd),
        .sign         (sign),
        .valid        (valid),
        .scroll_left  (scroll_left),
        .scroll_right (scroll_right),
        .an           (an),
        .seg          (seg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [10:0] observed, input logic [10:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got an=%b seg=%b, want an=%b seg=%b",
                     tag, observed[10:7], observed[6:0], expected[10:7], expected[6:0]);
        end
    endtask

    task automatic stepTo(input int t);
        while (e < t) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic expectAt(input int t, input string tag, input logic [3:0] expAn, input logic [6:0] expSeg);
        stepTo(t);
        checkOutput(tag, {an, seg}, {expAn, expSeg});
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic v,
                                 input logic [19:0] b, input logic s);
        scroll_left  = l;
        scroll_right = r;
        valid        = v;
        bcd          = b;
        sign         = s;
        stepTo(e + 1);
        scroll_left  = 1'b0;
        scroll_right = 1'b0;
        valid        = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bcd = '0; sign = 1'b0; valid = 1'b0;
        scroll_left = 1'b0; scroll_right = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("in_reset", {an, seg}, {4'b1111, GBLANK});
        rst = 1'b0;
        e   = 0;

        expectAt(1, "first_edge", 4'b1110, G0);
        expectAt(4, "pos0_hold", 4'b1110, G0);
        expectAt(5, "pos1_step", 4'b1101, G0);

        applyStimulus(1'b0, 1'b0, 1'b1, 20'h12345, 1'b1);
        expectAt(9,  "load_pos2", 4'b1011, G3);
        expectAt(13, "load_pos3", 4'b0111, G2);
        expectAt(17, "load_pos0", 4'b1110, G5);
        expectAt(21, "load_pos1", 4'b1101, G4);
        expectAt(24, "load_pos1_end", 4'b1101, G4);

        applyStimulus(1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
        expectAt(27, "off2_pos2", 4'b1011, G1);
        expectAt(29, "off2_minus", 4'b0111, GMINUS);
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
        expectAt(31, "left_sat_pos3", 4'b0111, GMINUS);
        expectAt(33, "left_sat_pos0", 4'b1110, G3);
        expectAt(37, "left_sat_pos1", 4'b1101, G2);

        applyStimulus(1'b0, 1'b1, 1'b0, 20'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 20'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 20'h0, 1'b0);
        expectAt(41, "right_sat_pos2", 4'b1011, G3);
        expectAt(45, "right_sat_pos3", 4'b0111, G2);

        applyStimulus(1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 20'h0, 1'b0);
        expectAt(49, "both_pos0", 4'b1110, G4);
        expectAt(53, "both_pos1", 4'b1101, G3);

        applyStimulus(1'b1, 1'b0, 1'b1, 20'h0A009, 1'b0);
        expectAt(57, "hexA_pos2", 4'b1011, G0);
        expectAt(61, "hexA_blank_sign", 4'b0111, GBLANK);
        expectAt(65, "hexA_pos0", 4'b1110, G0);
        expectAt(69, "hexA_nibbleA", 4'b1101, GBLANK);

        applyStimulus(1'b0, 1'b1, 1'b0, 20'h0, 1'b0);
        stepTo(73);
        rst = 1'b1;
        expectAt(74, "mid_scan_reset", 4'b1111, GBLANK);
        stepTo(75);
        rst = 1'b0;
        e   = 0;

        expectAt(1,  "rerun_pos0", 4'b1110, G0);
        expectAt(4,  "rerun_pos0_end", 4'b1110, G0);
        expectAt(5,  "rerun_pos1", 4'b1101, G0);
        expectAt(9,  "rerun_pos2", 4'b1011, G0);
        expectAt(13, "rerun_pos3", 4'b0111, G0);
        applyStimulus(1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
        expectAt(29, "rerun_off1_pos3", 4'b0111, G0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
